// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: md_op encoding, FSM state
// type and counter-width helper.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MDU_MULT_LAT_DEF = 5;
  localparam int unsigned MDU_DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Width that holds max(a,b)-1; never narrower than one bit.
  function automatic int unsigned mdu_cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned MDU_CNT_W = mdu_cnt_w(MDU_MULT_LAT_DEF, MDU_DIV_LAT_DEF);

  function automatic logic mdu_is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including
// divide-by-zero (keep current HI/LO) and signed overflow handling.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, div_a, div_b, q_mag, r_mag;
  logic        neg_q, neg_r, sgn;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    prod   = '0;
    sgn    = (md_op == MD_DIV);
    abs_a  = (sgn && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    abs_b  = (sgn && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    neg_q  = sgn && (rs_val[31] ^ rt_val[31]);
    neg_r  = sgn && rs_val[31];
    // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 rem 0 naturally.
    div_a  = abs_a;
    div_b  = (rt_val == '0) ? 32'd1 : abs_b;
    q_mag  = div_a / div_b;
    r_mag  = div_a % div_b;

    case (md_op)
      MD_MULT: begin
        prod   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, rs_val} * {32'd0, rt_val};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (rt_val != '0) begin
          res_lo = neg_q ? (32'd0 - q_mag) : q_mag;
          res_hi = neg_r ? (32'd0 - r_mag) : r_mag;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: latency countdown, HI/LO commit and D-stage stall.
// Optional MDU_FLUSH_EN lets flush abort an in-flight op or suppress a start.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = mdu_cnt_w(MULT_LAT, DIV_LAT);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] res_hi, res_lo;
  logic        flush_eff;

`ifdef MDU_FLUSH_EN
  assign flush_eff = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_eff    = 1'b0;
`endif

  mdu_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush_eff) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = CW'(MULT_LAT - 1);
              state_d   = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = CW'(DIV_LAT - 1);
              state_d   = ST_BUSY;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (flush_eff) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_BUSY);
    stall_req = d_is_md & (busy | (start & mdu_is_muldiv(md_op)));
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: expected HI/LO and latency are queued at issue
// and checked when busy falls.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int unsigned MLAT = 5;
  localparam int unsigned DLAT = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, d_is_md, flush;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  logic [31:0] m_hi, m_lo;
  exp_t        sb_q[$];

  mdu_seq #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_is_md   (d_is_md),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV:   return (b == 0) ? {ch, cl} : {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  return (b == 0) ? {ch, cl} : {32'(ua % ub), 32'(ua / ub)};
      MD_MTHI:  return {a, cl};
      MD_MTLO:  return {ch, a};
      default:  return {ch, cl};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd);
    exp_t e;
    logic [63:0] r;
    logic md;
    int unsigned n;
    md = (op <= MD_DIVU);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_is_md = dmd;
    #1;
    check_eq("busy_at_start", {63'd0, busy}, 64'd0);
    check_eq("stall_at_start", {63'd0, stall_req}, {63'd0, dmd & md});
    r    = model(op, a, b, m_hi, m_lo);
    m_hi = r[63:32];
    m_lo = r[31:0];
    e.hi = m_hi;
    e.lo = m_lo;
    e.lat = (op == MD_MULT || op == MD_MULTU) ? MLAT : (md ? DLAT : 0);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    #1;
    n = 0;
    while (busy && n < 200) begin
      if (dmd) check_eq("stall_busy", {63'd0, stall_req}, 64'd1);
      n++;
      @(negedge clk);
      #1;
    end
    e = sb_q.pop_front();
    check_eq("busy_cycles", 64'(n), 64'(e.lat));
    check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
    check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
    check_eq("stall_after", {63'd0, stall_req}, 64'd0);
    d_is_md = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; d_is_md = 1'b0; flush = 1'b0;
    md_op = '0; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_req}, 64'd0);
    reset = 1'b0;

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7, 1'b1);
    run_op(MD_DIVU,  32'd100, 32'd7, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIV,   32'd17, 32'hFFFF_FFFB, 1'b0);
    run_op(MD_MTHI,  32'd5, 32'd0, 1'b1);
    run_op(MD_MTLO,  32'd9, 32'd0, 1'b0);
    run_op(MD_DIV,   32'd1234, 32'd0, 1'b1);
    run_op(MD_MTHI,  32'h1234, 32'd0, 1'b0);
    run_op(3'd6,     32'hDEAD_BEEF, 32'd3, 1'b1);
    run_op(MD_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    // Reset in the middle of a multiply discards the pending result.
    @(negedge clk);
    start = 1'b1; md_op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_hi", {32'd0, hi}, 64'd0);
    check_eq("midrst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0; m_hi = '0; m_lo = '0;
    repeat (MLAT + 2) @(negedge clk);
    #1;
    check_eq("midrst_lo_late", {32'd0, lo}, 64'd0);
    check_eq("midrst_busy_late", {63'd0, busy}, 64'd0);

`ifdef MDU_FLUSH_EN
    run_op(MD_MTLO, 32'h55, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("flush_lo", {32'd0, lo}, {32'd0, m_lo});
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = MD_MTHI; rs_val = 32'hABCD;
    @(negedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check_eq("flush_mthi", {32'd0, hi}, {32'd0, m_hi});
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
